// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg
//   Shared definitions for the pipelined approximate multiplier:
//   - MAX_PROD_W  : widest product the column-mask helper supports
//   - MODE_EXACT / MODE_APPROX : per-transaction mode encoding
//   - col_mask()  : column keep-mask, bit k set iff k >= trunc
//   - row_split() : number of partial-product rows in the low partial sum
package approx_mult_pkg;

  localparam int MAX_PROD_W = 128;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Keep-mask over product columns; columns below trunc are dropped.
  function automatic logic [MAX_PROD_W-1:0] col_mask(input int trunc);
    logic [MAX_PROD_W-1:0] m;
    m = '0;
    for (int k = 0; k < MAX_PROD_W; k++) begin
      m[k] = (k >= trunc);
    end
    return m;
  endfunction

  // Rows 0..row_split(width)-1 form the low partial sum.
  function automatic int row_split(input int width);
    return width / 32'sd2;
  endfunction

endpackage

// File: rtl/approx_mult_pipe_rowsum.sv
// approx_pp_rowsum
//   Combinational sum of partial-product rows ROW_LO..ROW_HI, where row j
//   is (x & {WIDTH{y[j]}}) << j. When i_approx is set, every bit that
//   lands in a column below TRUNC is forced to zero before summing.
//   Ports:
//     i_x, i_y  : unsigned operands
//     i_approx  : 1 = apply column truncation
//     o_sum     : masked row sum, 2*WIDTH bits
module approx_pp_rowsum
  import approx_mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int TRUNC  = 8,
  parameter int ROW_LO = 0,
  parameter int ROW_HI = 3
) (
  input  logic [WIDTH-1:0]   i_x,
  input  logic [WIDTH-1:0]   i_y,
  input  logic               i_approx,
  output logic [2*WIDTH-1:0] o_sum
);

  localparam int PW = 2 * WIDTH;
  localparam logic [MAX_PROD_W-1:0] C_MASK_FULL = col_mask(TRUNC);
  localparam logic [PW-1:0]         C_MASK      = C_MASK_FULL[PW-1:0];

  logic [PW-1:0] w_mask;
  logic [PW-1:0] w_row;
  logic [PW-1:0] w_sum;

  // Accumulate the selected rows. Every row is formed so that all of i_y
  // is referenced; rows outside ROW_LO..ROW_HI simply do not contribute.
  always_comb begin
    w_mask = {PW{1'b1}};
    w_row  = '0;
    w_sum  = '0;
    if (i_approx) begin
      w_mask = C_MASK;
    end else begin
      w_mask = {PW{1'b1}};
    end
    for (int j = 0; j < WIDTH; j++) begin
      w_row = {{WIDTH{1'b0}}, (i_x & {WIDTH{i_y[j]}})} << j;
      if ((j >= ROW_LO) && (j <= ROW_HI)) begin
        w_sum = w_sum + (w_row & w_mask);
      end else begin
        w_sum = w_sum;
      end
    end
  end

  assign o_sum = w_sum;

endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe
//   Two-stage pipelined unsigned approximate multiplier with valid/ready
//   handshake and full backpressure.
//     Stage A: registers the low-row and high-row masked partial sums + mode.
//     Stage B: registers z = PL + PH (+ COMP in approximate mode).
//   Ports:
//     clk, rst_n          : clock (rising edge), async active-low reset
//     in_valid / in_ready : operand handshake
//     x, y, mode          : operands and mode (0 exact, 1 approximate)
//     out_valid/out_ready : result handshake
//     z, z_mode           : product and the mode that produced it
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter int          TRUNC = 8,
  parameter int unsigned COMP  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic               z_mode
);

  localparam int            PW     = 2 * WIDTH;
  localparam int            SPLIT  = row_split(WIDTH);
  localparam logic [PW-1:0] C_COMP = PW'(COMP);

  logic          w_approx;
  logic [PW-1:0] w_pl;
  logic [PW-1:0] w_ph;
  logic          w_ready_a;
  logic          w_ready_b;
  logic [PW-1:0] w_sum_b;

  logic          r_va;
  logic [PW-1:0] r_pl;
  logic [PW-1:0] r_ph;
  logic          r_mode_a;
  logic          r_vb;
  logic [PW-1:0] r_z;
  logic          r_zmode;

  assign w_approx = (mode == MODE_APPROX);

  approx_pp_rowsum #(
    .WIDTH (WIDTH),
    .TRUNC (TRUNC),
    .ROW_LO(0),
    .ROW_HI(SPLIT - 1)
  ) u_row_lo (
    .i_x     (x),
    .i_y     (y),
    .i_approx(w_approx),
    .o_sum   (w_pl)
  );

  approx_pp_rowsum #(
    .WIDTH (WIDTH),
    .TRUNC (TRUNC),
    .ROW_LO(SPLIT),
    .ROW_HI(WIDTH - 1)
  ) u_row_hi (
    .i_x     (x),
    .i_y     (y),
    .i_approx(w_approx),
    .o_sum   (w_ph)
  );

  // A stage may load whenever it is empty or its successor moves this cycle,
  // so bubbles collapse regardless of out_ready.
  assign w_ready_b = !r_vb || out_ready;
  assign w_ready_a = !r_va || w_ready_b;
  assign in_ready  = w_ready_a;

  // Final addition; the compensation constant applies only to approximate results.
  always_comb begin
    w_sum_b = r_pl + r_ph;
    if (r_mode_a == MODE_APPROX) begin
      w_sum_b = r_pl + r_ph + C_COMP;
    end else begin
      w_sum_b = r_pl + r_ph;
    end
  end

  // Stage A: capture operands' partial sums only on an accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_va     <= 1'b0;
      r_pl     <= '0;
      r_ph     <= '0;
      r_mode_a <= 1'b0;
    end else if (w_ready_a) begin
      r_va <= in_valid;
      if (in_valid) begin
        r_pl     <= w_pl;
        r_ph     <= w_ph;
        r_mode_a <= mode;
      end
    end
  end

  // Stage B: holds z/z_mode stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vb    <= 1'b0;
      r_z     <= '0;
      r_zmode <= 1'b0;
    end else if (w_ready_b) begin
      r_vb <= r_va;
      if (r_va) begin
        r_z     <= w_sum_b;
        r_zmode <= r_mode_a;
      end
    end
  end

  assign out_valid = r_vb;
  assign z         = r_z;
  assign z_mode    = r_zmode;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe. Three instances share the
// stimulus: defaults (TRUNC=8, COMP=0), COMP=128, and TRUNC=0 (approximate
// must equal exact). Inputs are driven just after the falling edge and all
// handshakes are evaluated 1 time unit later, i.e. with the values the next
// rising edge will see.
module tb_approx_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        mode;
  logic        out_ready;

  logic        in_ready,  in_ready_c,  in_ready_t;
  logic        out_valid, out_valid_c, out_valid_t;
  logic [15:0] z,         z_c,         z_t;
  logic        z_mode,    z_mode_c,    z_mode_t;

  always #5 clk = ~clk;

  approx_mult_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .z_mode(z_mode)
  );

  approx_mult_pipe #(.WIDTH(8), .TRUNC(8), .COMP(128)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .x(x), .y(y), .mode(mode), .out_valid(out_valid_c), .out_ready(out_ready),
    .z(z_c), .z_mode(z_mode_c)
  );

  approx_mult_pipe #(.WIDTH(8), .TRUNC(0), .COMP(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
    .x(x), .y(y), .mode(mode), .out_valid(out_valid_t), .out_ready(out_ready),
    .z(z_t), .z_mode(z_mode_t)
  );

  typedef struct {
    logic [15:0] z_def;
    logic [15:0] z_comp;
    logic [15:0] z_t0;
    logic        m;
    int          acc;
    logic        lat;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        m;
    logic [15:0] z_def;
    logic [15:0] z_comp;
  } vec_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact product, minus the weight of every dropped bit pair,
  // plus the compensation constant.
  function automatic logic [15:0] ref_z(input logic [7:0] a, input logic [7:0] b,
                                        input logic m, input int trunc, input int comp);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    if (m) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          if (a[i] && b[j] && ((i + j) < trunc)) p = p - 16'(32'd1 << (i + j));
        end
      end
      p = p + 16'(comp);
    end
    return p;
  endfunction

  // One clock of stimulus plus all handshake-time checks.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic m, input logic ordy, input logic [15:0] ez,
                       input logic [15:0] ezc, input logic lat);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    x         = a;
    y         = b;
    mode      = m;
    out_ready = ordy;
    #1;
    cyc++;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (sb.size() < 2) || ordy});
    chk("in_ready_c", {31'd0, in_ready_c}, {31'd0, in_ready});
    chk("in_ready_t0", {31'd0, in_ready_t}, {31'd0, in_ready});
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("z", {16'd0, z}, {16'd0, e.z_def});
        chk("z_mode", {31'd0, z_mode}, {31'd0, e.m});
        chk("z_comp128", {16'd0, z_c}, {16'd0, e.z_comp});
        chk("z_mode_comp128", {31'd0, z_mode_c}, {31'd0, e.m});
        chk("z_trunc0", {16'd0, z_t}, {16'd0, e.z_t0});
        if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd2);
      end
    end else if (out_valid && !out_ready && (sb.size() > 0)) begin
      chk("stall_z", {16'd0, z}, {16'd0, sb[0].z_def});
      chk("stall_z_mode", {31'd0, z_mode}, {31'd0, sb[0].m});
    end
    if (v && in_ready) begin
      e.z_def  = ez;
      e.z_comp = ezc;
      e.z_t0   = 16'(a) * 16'(b);
      e.m      = m;
      e.acc    = cyc;
      e.lat    = lat;
      sb.push_back(e);
    end
  endtask

  task automatic drive_model(input logic [7:0] a, input logic [7:0] b,
                             input logic m, input logic ordy, input logic lat);
    cycle(1'b1, a, b, m, ordy, ref_z(a, b, m, 8, 0), ref_z(a, b, m, 8, 128), lat);
  endtask

  task automatic drain();
    for (int k = 0; (k < 20) && (sb.size() > 0); k++) begin
      cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b0);
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  vec_t vecs[6];
  logic saw_full;
  logic [7:0] ra, rb;

  initial begin
    // Hand-computed vectors: default instance and COMP=128 instance.
    vecs[0] = '{8'd255, 8'd255, 1'b0, 16'd65025, 16'd65025};
    vecs[1] = '{8'd255, 8'd255, 1'b1, 16'd63232, 16'd63360};
    vecs[2] = '{8'd1,   8'd1,   1'b1, 16'd0,     16'd128};
    vecs[3] = '{8'd128, 8'd2,   1'b1, 16'd256,   16'd384};
    vecs[4] = '{8'd0,   8'd0,   1'b1, 16'd0,     16'd128};
    vecs[5] = '{8'd0,   8'd0,   1'b0, 16'd0,     16'd0};

    rst_n = 1'b0; in_valid = 1'b0; x = 8'd0; y = 8'd0; mode = 1'b0; out_ready = 1'b1;
    #3;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_z", {16'd0, z}, 32'd0);
    chk("reset_z_mode", {31'd0, z_mode}, 32'd0);
    #19 rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Table vectors, back to back, latency checked.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].m, 1'b1, vecs[i].z_def, vecs[i].z_comp, 1'b1);
    end
    drain();

    // Stream of 10 with alternating mode.
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      drive_model(ra, rb, i[0], 1'b1, 1'b1);
    end
    drain();

    // Backpressure: first result drains, then consumer stalls with input pressure.
    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      drive_model(ra, rb, i[0], 1'b1, 1'b0);
    end
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      drive_model(ra, rb, ~i[0], 1'b0, 1'b0);
      if (!in_ready) saw_full = 1'b1;
    end
    chk("bp_in_ready_fell", {31'd0, saw_full}, 32'd1);
    drain();

    // Async reset with two transactions in flight.
    drive_model(8'd200, 8'd3, 1'b0, 1'b1, 1'b1);
    drive_model(8'd17, 8'd99, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_z", {16'd0, z}, 32'd0);
    chk("rst_z_c", {16'd0, z_c}, 32'd0);
    sb.delete();
    cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b0);
      chk("no_stale_out_valid", {31'd0, out_valid}, 32'd0);
    end
    drive_model(8'd13, 8'd11, 1'b0, 1'b1, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
